// File: rtl/player_input_capture.sv
// player_input_capture
//   Reads the player's reply to a flashed colour sequence. The four colour
//   switches are synchronised and debounced, and one-hot press/release events
//   are derived from the debounced value. Each press is encoded to a 2-bit
//   colour and compared in order against segment[0..len-1]. The block reports
//   a one-cycle round_done, or a held fail level with a reason code.
//
// State table
//   state        | meaning
//   IDLE         | no round in progress
//   WAIT_CLEAR   | armed while switches were held; waiting for all released
//   WAIT_PRESS   | waiting for the next press; tick pulses count toward timeout
//   WAIT_RELEASE | correct colour accepted; waiting for all switches released
//   DONE         | all entries matched; emits round_done for one cycle
//   FAIL         | round failed; fail/fail_code held until the next arm
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   player_input in   raw switches SW[3:0], asynchronous to clk
//   tick         in   one-cycle timer pulse used for the press timeout
//   arm          in   one-cycle start of a round (accepted in every state)
//   round_len    in   entries expected this round, sampled on arm
//   segment      in   expected colour sequence, entry 0 first
//   colour_o     out  colour of the last accepted press
//   colour_valid out  one-cycle strobe when a press is accepted
//   entry_idx    out  index of the next expected entry
//   busy         out  high while a round is being captured
//   round_done   out  one-cycle pulse when all entries matched
//   fail         out  failure level, held until the next arm
//   fail_code    out  00 none, 01 wrong colour, 10 multi-switch, 11 timeout

module player_input_capture #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int TIMEOUT_PULSES  = 8,
  parameter int MAX_ROUND       = 33
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                player_input,
  input  logic                      tick,
  input  logic                      arm,
  input  logic [5:0]                round_len,
  input  logic [MAX_ROUND-1:0][1:0] segment,
  output logic [1:0]                colour_o,
  output logic                      colour_valid,
  output logic [5:0]                entry_idx,
  output logic                      busy,
  output logic                      round_done,
  output logic                      fail,
  output logic [1:0]                fail_code
);

  localparam int TO_W = $clog2(TIMEOUT_PULSES + 1);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_WRONG = 2'b01;
  localparam logic [1:0] CODE_MULTI = 2'b10;
  localparam logic [1:0] CODE_TOUT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CLEAR,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE,
    FAIL
  } state_t;

  state_t           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       sync_q;
  logic [3:0]       stable_q;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [5:0]       len_q;

  logic       press_w;
  logic       release_w;
  logic       onehot_w;
  logic [1:0] enc_w;
  logic [5:0] len_clamp_w;
  logic [5:0] idx_next_w;

  // Two-flop synchroniser on the raw switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'b0;
      sync_q  <= 4'b0;
    end else begin
      sync1_q <= player_input;
      sync_q  <= sync1_q;
    end
  end

  // Debounce: sync must differ from stable for DEBOUNCE_CYCLES consecutive
  // cycles before stable follows it; any return to the stable value restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= 4'b0;
      prev_q   <= 4'b0;
      db_cnt_q <= '0;
    end else begin
      prev_q <= stable_q;
      if (sync_q == stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Events are edges of the debounced value, seen one cycle after stable moves.
  assign press_w   = (prev_q == 4'b0) && (stable_q != 4'b0);
  assign release_w = (prev_q != 4'b0) && (stable_q == 4'b0);
  assign onehot_w  = ((stable_q & (stable_q - 4'd1)) == 4'b0);

  always_comb begin
    enc_w = 2'd0;
    case (stable_q)
      4'b0010: enc_w = 2'd1;
      4'b0100: enc_w = 2'd2;
      4'b1000: enc_w = 2'd3;
      default: enc_w = 2'd0;
    endcase
  end

  assign len_clamp_w = (round_len > 6'(MAX_ROUND)) ? 6'(MAX_ROUND) : round_len;
  assign idx_next_w  = entry_idx + 6'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      len_q        <= 6'd0;
      colour_o     <= 2'd0;
      colour_valid <= 1'b0;
      entry_idx    <= 6'd0;
      busy         <= 1'b0;
      round_done   <= 1'b0;
      fail         <= 1'b0;
      fail_code    <= CODE_NONE;
    end else begin
      colour_valid <= 1'b0;
      round_done   <= 1'b0;
      if (arm) begin
        entry_idx <= 6'd0;
        len_q     <= len_clamp_w;
        fail      <= 1'b0;
        fail_code <= CODE_NONE;
        to_cnt_q  <= '0;
        if (len_clamp_w == 6'd0) begin
          state_q <= DONE;
          busy    <= 1'b0;
        end else if (stable_q != 4'b0) begin
          // Switches already down at arm must not count as the first press.
          state_q <= WAIT_CLEAR;
          busy    <= 1'b1;
        end else begin
          state_q <= WAIT_PRESS;
          busy    <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: ;
          WAIT_CLEAR: begin
            if (stable_q == 4'b0) state_q <= WAIT_PRESS;
          end
          WAIT_PRESS: begin
            // A press in the same cycle as the final tick takes priority.
            if (press_w) begin
              if (onehot_w) begin
                colour_valid <= 1'b1;
                colour_o     <= enc_w;
                if (enc_w == segment[entry_idx]) begin
                  state_q <= WAIT_RELEASE;
                end else begin
                  state_q   <= FAIL;
                  busy      <= 1'b0;
                  fail      <= 1'b1;
                  fail_code <= CODE_WRONG;
                end
              end else begin
                state_q   <= FAIL;
                busy      <= 1'b0;
                fail      <= 1'b1;
                fail_code <= CODE_MULTI;
              end
            end else if (tick) begin
              if (to_cnt_q == TO_W'(TIMEOUT_PULSES - 1)) begin
                state_q   <= FAIL;
                busy      <= 1'b0;
                fail      <= 1'b1;
                fail_code <= CODE_TOUT;
              end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
              end
            end
          end
          WAIT_RELEASE: begin
            if (release_w) begin
              entry_idx <= idx_next_w;
              to_cnt_q  <= '0;
              if (idx_next_w == len_q) begin
                state_q <= DONE;
                busy    <= 1'b0;
              end else begin
                state_q <= WAIT_PRESS;
              end
            end
          end
          DONE: begin
            round_done <= 1'b1;
            state_q    <= IDLE;
          end
          FAIL: ;
          default: begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
